// File: rtl/step_scheduler.sv
// Step-pulse scheduler: host-filled move queue, wake times compared against the
// free-running counter, one-cycle step pulses on the due cycle.
module step_scheduler #(
    parameter int QUEUE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] counter,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        step,
    output logic        dir
);
    // state | meaning
    // IDLE  | waiting for a queued move
    // LOAD  | pop head entry, discard zero-count entries
    // RUN   | compare wake time against counter, emit steps
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

    state_t        state_q, state_d;
    logic [4:0]    level_q, level_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          overflow_q, overflow_d;
    logic [31:0]   next_time_q, next_time_d;
    logic [31:0]   interval_q, interval_d;
    logic [15:0]   add_q, add_d;
    logic [15:0]   remaining_q, remaining_d;
    logic [31:0]   staged_q, staged_d;
    logic          step_q, step_d;
    logic          dir_q, dir_d;

    logic [31:0] q_int [QUEUE_DEPTH];
    logic [15:0] q_cnt [QUEUE_DEPTH];
    logic [15:0] q_add [QUEUE_DEPTH];

    logic        wr_en, wr_push, wr_clr, full, empty, push, pop, due;
    logic [31:0] head_int, add_sext, diff;
    logic [15:0] head_cnt, head_add;

    assign wr_en    = wb_cyc_i && wb_stb_i && wb_we_i;
    assign wr_push  = wr_en && (wb_adr_i == 4'd1);
    assign wr_clr   = wr_en && (wb_adr_i == 4'd4) && wb_dat_i[0];
    assign full     = (level_q == 5'(QUEUE_DEPTH));
    assign empty    = (level_q == 5'd0);
    assign push     = wr_push && !full && !wr_clr;
    assign head_int = q_int[rd_ptr_q];
    assign head_cnt = q_cnt[rd_ptr_q];
    assign head_add = q_add[rd_ptr_q];
    assign add_sext = {{16{add_q[15]}}, add_q};
    assign diff     = counter - next_time_q;
    // Suppressing due while a pulse is out keeps pulses at least two cycles apart.
    assign due      = !diff[31] && !step_q;

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q | (wr_push && full);
        next_time_d = next_time_q;
        interval_d  = interval_q;
        add_d       = add_q;
        remaining_d = remaining_q;
        staged_d    = staged_q;
        step_d      = 1'b0;
        dir_d       = dir_q;
        pop         = 1'b0;

        if (wr_en && (wb_adr_i == 4'd0)) staged_d = wb_dat_i;
        if (wr_en && (wb_adr_i == 4'd2)) dir_d = wb_dat_i[0];

        case (state_q)
            ST_IDLE: begin
                if (wr_en && (wb_adr_i == 4'd3)) next_time_d = wb_dat_i;
                if (!empty) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (empty) begin
                    state_d = ST_IDLE;
                end else begin
                    pop = 1'b1;
                    if (head_cnt == 16'd0) begin
                        state_d = (level_q > 5'd1) ? ST_LOAD : ST_IDLE;
                    end else begin
                        interval_d  = head_int;
                        add_d       = head_add;
                        remaining_d = head_cnt;
                        next_time_d = next_time_q + head_int;
                        state_d     = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (due) begin
                    step_d = 1'b1;
                    if (remaining_q <= 16'd1) begin
                        remaining_d = 16'd0;
                        state_d     = empty ? ST_IDLE : ST_LOAD;
                    end else begin
                        remaining_d = remaining_q - 16'd1;
                        interval_d  = interval_q + add_sext;
                        next_time_d = next_time_q + interval_q + add_sext;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        level_d  = level_q + {4'd0, push} - {4'd0, pop};

        if (wr_clr) begin
            state_d     = ST_IDLE;
            level_d     = 5'd0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            remaining_d = 16'd0;
            overflow_d  = 1'b0;
            step_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            level_q     <= 5'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            next_time_q <= 32'd0;
            interval_q  <= 32'd0;
            add_q       <= 16'd0;
            remaining_q <= 16'd0;
            staged_q    <= 32'd0;
            step_q      <= 1'b0;
            dir_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            next_time_q <= next_time_d;
            interval_q  <= interval_d;
            add_q       <= add_d;
            remaining_q <= remaining_d;
            staged_q    <= staged_d;
            step_q      <= step_d;
            dir_q       <= dir_d;
        end
    end

    // Queue storage needs no reset; occupancy is tracked by the pointers and level.
    always_ff @(posedge clk) begin
        if (push) begin
            q_int[wr_ptr_q] <= staged_q;
            q_cnt[wr_ptr_q] <= wb_dat_i[15:0];
            q_add[wr_ptr_q] <= wb_dat_i[31:16];
        end
    end

    always_comb begin
        case (wb_adr_i)
            4'd0:    wb_dat_o = {overflow_q, 23'd0, state_q, 1'b0, level_q};
            4'd1:    wb_dat_o = next_time_q;
            4'd2:    wb_dat_o = {16'd0, remaining_q};
            4'd3:    wb_dat_o = interval_q;
            default: wb_dat_o = 32'd0;
        endcase
    end

    assign wb_ack_o = 1'b1;
    assign step     = step_q;
    assign dir      = dir_q;
endmodule

// File: tb/tb_step_scheduler.sv
// Directed bench for step_scheduler: expected step times are queued with each
// move and matched against pulses captured from the DUT.
module tb_step_scheduler;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] cnt = 32'd0;
    logic        cnt_load = 1'b0;
    logic [31:0] cnt_val = 32'd0;
    logic        wb_stb = 1'b0, wb_cyc = 1'b0, wb_we = 1'b0;
    logic [3:0]  wb_adr = 4'd0;
    logic [31:0] wb_dat_w = 32'd0;
    logic [31:0] wb_dat_r;
    logic        wb_ack, step, dir;

    int          n_assert = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    logic [31:0] d;

    step_scheduler #(.QUEUE_DEPTH(4)) dut (
        .clk(clk), .rst(rst_n), .counter(cnt),
        .wb_stb_i(wb_stb), .wb_cyc_i(wb_cyc), .wb_we_i(wb_we),
        .wb_adr_i(wb_adr), .wb_dat_i(wb_dat_w),
        .wb_dat_o(wb_dat_r), .wb_ack_o(wb_ack),
        .step(step), .dir(dir)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cnt <= cnt_load ? cnt_val : cnt + 32'd1;

    // The counter has already advanced once when the pulse is visible.
    always @(negedge clk) if (step === 1'b1) obs_q.push_back(cnt - 32'd1);

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
        n_assert++;
        assert (obs_v === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs_v, exp_v);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] v);
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = a; wb_dat_w = v;
        @(negedge clk);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] v);
        @(negedge clk);
        wb_we = 1'b0; wb_adr = a;
        #1 v = wb_dat_r;
    endtask

    task automatic set_cnt(input logic [31:0] v);
        @(negedge clk);
        cnt_load = 1'b1; cnt_val = v;
        @(negedge clk);
        cnt_load = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        int k = 0;
        logic [31:0] e, o;
        while (obs_q.size() < exp_q.size() && k < budget) begin
            @(negedge clk);
            k++;
        end
        repeat (6) @(negedge clk);
        chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() > 0) o = obs_q.pop_front();
            else o = 32'hDEAD_BEEF;
            chk(tag, o, e);
        end
        obs_q.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rd(4'd0, d); chk("reset_status", d, 32'h0);
        chk("reset_step", {31'd0, step}, 32'd0);
        chk("reset_dir", {31'd0, dir}, 32'd0);

        // Constant-interval move
        set_cnt(32'd0);
        wr(4'd3, 32'd100);
        wr(4'd0, 32'd50);
        wr(4'd1, {16'd0, 16'd3});
        exp_q.push_back(32'd150); exp_q.push_back(32'd200); exp_q.push_back(32'd250);
        drain("move1", 400);
        rd(4'd0, d); chk("move1_idle", d, 32'h0);
        rd(4'd2, d); chk("move1_remaining", d, 32'd0);
        rd(4'd1, d); chk("move1_next_time", d, 32'd250);

        wr(4'd2, 32'd1);
        chk("dir_set", {31'd0, dir}, 32'd1);

        // Acceleration: add = -10
        set_cnt(32'd0);
        wr(4'd3, 32'd0);
        wr(4'd0, 32'd100);
        wr(4'd1, {16'hFFF6, 16'd3});
        exp_q.push_back(32'd100); exp_q.push_back(32'd190); exp_q.push_back(32'd270);
        drain("accel", 400);
        rd(4'd3, d); chk("accel_interval", d, 32'd80);
        rd(4'd1, d); chk("accel_next_time", d, 32'd270);

        // Counter wrap
        set_cnt(32'hFFFF_FFE0);
        wr(4'd3, 32'hFFFF_FFF0);
        wr(4'd0, 32'h20);
        wr(4'd1, {16'd0, 16'd1});
        exp_q.push_back(32'h0000_0010);
        drain("wrap", 200);

        // Back-to-back moves with a zero-count entry between them
        set_cnt(32'd0);
        wr(4'd3, 32'd1000);
        wr(4'd0, 32'd40);  wr(4'd1, {16'd0, 16'd2});
        wr(4'd0, 32'd999); wr(4'd1, {16'd0, 16'd0});
        wr(4'd0, 32'd30);  wr(4'd1, {16'd0, 16'd1});
        exp_q.push_back(32'd1040); exp_q.push_back(32'd1080); exp_q.push_back(32'd1110);
        drain("b2b", 1500);
        rd(4'd1, d); chk("b2b_next_time", d, 32'd1110);

        // Overflow and clear
        set_cnt(32'd0);
        wr(4'd3, 32'h4000_0000);
        wr(4'd0, 32'd16);
        repeat (4) wr(4'd1, {16'd0, 16'd1});
        rd(4'd0, d); chk("ovf_level3", d, 32'h0000_0083);
        wr(4'd1, {16'd0, 16'd1});
        rd(4'd0, d); chk("ovf_level4", d, 32'h0000_0084);
        wr(4'd1, {16'd0, 16'd1});
        rd(4'd0, d); chk("ovf_dropped", d, 32'h8000_0084);
        wr(4'd4, 32'd1);
        rd(4'd0, d); chk("clear_status", d, 32'h0);
        rd(4'd2, d); chk("clear_remaining", d, 32'd0);
        rd(4'd1, d); chk("clear_next_time_kept", d, 32'h4000_0010);
        chk("clear_dir_kept", {31'd0, dir}, 32'd1);
        drain("ovf_nostep", 10);

        // Asynchronous reset in the middle of a move
        set_cnt(32'd0);
        wr(4'd3, 32'd0);
        wr(4'd0, 32'd20);
        wr(4'd1, {16'd0, 16'd5});
        begin
            int k = 0;
            while (obs_q.size() < 1 && k < 200) begin
                @(negedge clk);
                k++;
            end
        end
        chk("rst_first_step_seen", 32'(obs_q.size()), 32'd1);
        #1 rst_n = 1'b0;
        #1 chk("rst_step", {31'd0, step}, 32'd0);
        chk("rst_dir", {31'd0, dir}, 32'd0);
        wb_adr = 4'd0; #1 chk("rst_status", wb_dat_r, 32'h0);
        wb_adr = 4'd1; #1 chk("rst_next_time", wb_dat_r, 32'h0);
        wb_adr = 4'd2; #1 chk("rst_remaining", wb_dat_r, 32'h0);
        wb_adr = 4'd3; #1 chk("rst_interval", wb_dat_r, 32'h0);
        exp_q.push_back(32'd20);
        drain("rst_pre", 5);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("rst_no_step", 32'(obs_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
